// File: rtl/pipo_load_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_load_arb
//  Purpose  : Four-way load arbiter that owns every write into one shared
//             WIDTH-bit PIPO holding register and hands the held word to a
//             single consumer over a valid/ready handshake.  It also keeps a
//             free-running 8-bit count of register loads for debug.
//
//  Ports    : clk       rising-edge clock
//             rst       synchronous, active-high reset
//             req[3:0]  per-lane load request
//             din       packed lanes, lane i = din[i*WIDTH +: WIDTH]
//             gnt[3:0]  one-cycle one-hot pulse marking the captured lane
//             q         held word
//             q_src     index of the lane whose word is in q
//             q_valid   q holds an unconsumed word
//             q_ready   consumer takes q when q_valid & q_ready at an edge
//             load_cnt  number of register loads, wraps 255 -> 0
//
//  Config   : PIPO_LOAD_ARB_RR_EN defined   -> round-robin winner selection
//             PIPO_LOAD_ARB_RR_EN undefined -> fixed priority, lane 0 highest
//
//  Revision : 1.0  initial release
// ============================================================================
module pipo_load_arb #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] din,
   output logic [3:0]         gnt,
   output logic [WIDTH-1:0]   q,
   output logic [1:0]         q_src,
   output logic               q_valid,
   input  logic               q_ready,
   output logic [7:0]         load_cnt
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   data_q,     data_d;
   logic [1:0]         src_q,      src_d;
   logic [3:0]         gnt_q,      gnt_d;
   logic [7:0]         load_cnt_q, load_cnt_d;
`ifdef PIPO_LOAD_ARB_RR_EN
   logic [1:0]         rr_ptr_q,   rr_ptr_d;
`endif

   logic [3:0]         eff_req;
   logic               load;
   logic [1:0]         win;
   logic               win_found;

   // A lane granted in this cycle is still showing the request that was just
   // served; masking it stops the same word being captured twice.
   assign eff_req = req & ~gnt_q;

   // Register can take a new word when it is empty or its word is leaving now.
   assign load = ((state_q == ST_EMPTY) || q_ready) && (eff_req != 4'b0000);

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
`ifdef PIPO_LOAD_ARB_RR_EN
   always_comb begin
      logic [1:0] idx;
      win       = 2'd0;
      win_found = 1'b0;
      idx       = 2'd0;
      // Scan starting at the lane after the previous winner; the 2-bit add
      // wraps naturally modulo four.
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr_q + 2'(k);
         if (!win_found && eff_req[idx]) begin
            win_found = 1'b1;
            win       = idx;
         end
      end
   end
`else
   always_comb begin
      win       = 2'd0;
      win_found = 1'b0;
      // Walk from lowest priority up so the last hit is the highest priority.
      for (int k = 3; k >= 0; k--) begin
         if (eff_req[k]) begin
            win_found = 1'b1;
            win       = 2'(k);
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      src_d      = src_q;
      gnt_d      = 4'b0000;
      load_cnt_d = load_cnt_q;
`ifdef PIPO_LOAD_ARB_RR_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      if (load && win_found) begin
         data_d     = din[win*WIDTH +: WIDTH];
         src_d      = win;
         gnt_d      = 4'b0001 << win;
         load_cnt_d = load_cnt_q + 8'd1;
         state_d    = ST_FULL;
`ifdef PIPO_LOAD_ARB_RR_EN
         rr_ptr_d   = win + 2'd1;
`endif
      end else begin
         case (state_q)
            ST_FULL: begin
               // Word consumed with nothing to replace it: q/q_src keep
               // their last value, only the valid flag drops.
               if (q_ready) begin
                  state_d = ST_EMPTY;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         data_q     <= '0;
         src_q      <= 2'd0;
         gnt_q      <= 4'b0000;
         load_cnt_q <= 8'd0;
`ifdef PIPO_LOAD_ARB_RR_EN
         rr_ptr_q   <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         src_q      <= src_d;
         gnt_q      <= gnt_d;
         load_cnt_q <= load_cnt_d;
`ifdef PIPO_LOAD_ARB_RR_EN
         rr_ptr_q   <= rr_ptr_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign q        = data_q;
   assign q_src    = src_q;
   assign q_valid  = (state_q == ST_FULL);
   assign load_cnt = load_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipo_load_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipo_load_arb
//  Purpose  : Self-checking bench for pipo_load_arb: directed scenarios with
//             constant expectations plus a randomized run compared against a
//             behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipo_load_arb;

   localparam int WIDTH = 4;

   logic               clk;
   logic               rst;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] din;
   logic [3:0]         gnt;
   logic [WIDTH-1:0]   q;
   logic [1:0]         q_src;
   logic               q_valid;
   logic               q_ready;
   logic [7:0]         load_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   // Behavioural model of the register contents.
   int m_q, m_src, m_valid, m_gnt, m_cnt, m_ptr;

   pipo_load_arb #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .din      (din),
      .gnt      (gnt),
      .q        (q),
      .q_src    (q_src),
      .q_valid  (q_valid),
      .q_ready  (q_ready),
      .load_cnt (load_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge; the model computes its next state from the
   // inputs presented to that edge.  Outputs are observed 1 time unit later.
   task automatic tick();
      int n_q, n_src, n_valid, n_gnt, n_cnt, n_ptr;
      int eff, base, w;
      n_q = m_q; n_src = m_src; n_valid = m_valid; n_gnt = 0;
      n_cnt = m_cnt; n_ptr = m_ptr;
      if (rst) begin
         n_q = 0; n_src = 0; n_valid = 0; n_cnt = 0; n_ptr = 0;
      end else begin
         eff = int'(req) & ~m_gnt & 15;
`ifdef PIPO_LOAD_ARB_RR_EN
         base = m_ptr;
`else
         base = 0;
`endif
         w = -1;
         if ((m_valid == 0 || q_ready) && eff != 0) begin
            for (int k = 0; k < 4; k++)
               if (w < 0 && ((eff >> ((base + k) % 4)) & 1) == 1)
                  w = (base + k) % 4;
         end
         if (w >= 0) begin
            n_q     = int'((din >> (w * WIDTH)) & 16'hF);
            n_src   = w;
            n_gnt   = 1 << w;
            n_valid = 1;
            n_cnt   = (m_cnt + 1) % 256;
            n_ptr   = (w + 1) % 4;
         end else if (m_valid == 1 && q_ready) begin
            n_valid = 0;
         end
      end
      @(posedge clk);
      #1;
      m_q = n_q; m_src = n_src; m_valid = n_valid; m_gnt = n_gnt;
      m_cnt = n_cnt; m_ptr = n_ptr;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; q_ready = 1'b0; din = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; q_ready = 1'b1; din = 16'h4321;
      for (int c = 0; c < 2; c++) begin
         tick();
         tests_run++;
         if (gnt !== 4'b0000 || q !== 4'h0 || q_valid !== 1'b0 || load_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: gnt=%b q=%h q_valid=%b load_cnt=%0d, required 0000 0 0 0",
                     gnt, q, q_valid, load_cnt);
         end
      end
      rst = 1'b0;
      #2;
      tests_run++;
      if (gnt !== 4'b0000 || q !== 4'h0 || q_valid !== 1'b0 || load_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_release: gnt=%b q=%h q_valid=%b load_cnt=%0d, required 0000 0 0 0",
                  gnt, q, q_valid, load_cnt);
      end
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || q !== 4'h1 || q_valid !== 1'b1 || load_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL reset_first_load: gnt=%b q=%h q_valid=%b load_cnt=%0d, required 0001 1 1 1",
                  gnt, q, q_valid, load_cnt);
      end
   endtask

   task automatic test_single_load();
      do_reset();
      req = 4'b0010; din = 16'h00A0; q_ready = 1'b0;
      tick();
      tests_run++;
      if (gnt !== 4'b0010 || q !== 4'hA || q_src !== 2'd1 || q_valid !== 1'b1 || load_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL single_load: gnt=%b q=%h q_src=%0d q_valid=%b cnt=%0d, required 0010 A 1 1 1",
                  gnt, q, q_src, q_valid, load_cnt);
      end
      req = 4'b0000; din = 16'h5555;
      for (int c = 0; c < 5; c++) begin
         tick();
         tests_run++;
         if (gnt !== 4'b0000 || q !== 4'hA || q_valid !== 1'b1 || load_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_hold[%0d]: gnt=%b q=%h q_valid=%b cnt=%0d, required 0000 A 1 1",
                     c, gnt, q, q_valid, load_cnt);
         end
      end
      q_ready = 1'b1;
      tick();
      tests_run++;
      if (q_valid !== 1'b0 || q !== 4'hA || q_src !== 2'd1) begin
         tests_failed++;
         $display("FAIL single_drain: q_valid=%b q=%h q_src=%0d, required 0 A 1", q_valid, q, q_src);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [5];
`ifdef PIPO_LOAD_ARB_RR_EN
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
      do_reset();
      req = 4'b1111; q_ready = 1'b1; din = 16'h8421;
      for (int c = 0; c < 5; c++) begin
         tick();
         tests_run++;
         if (gnt !== exp_seq[c] || q_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL arb_order[%0d]: gnt=%b q_valid=%b, required %b 1",
                     c, gnt, q_valid, exp_seq[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req = 4'b0001; din = 16'h0003; q_ready = 1'b0;
      tick();
      req = 4'b1000; din = 16'h5000; q_ready = 1'b1;
      tick();
      tests_run++;
      if (q !== 4'h5 || q_src !== 2'd3 || q_valid !== 1'b1 || gnt !== 4'b1000 || load_cnt !== 8'd2) begin
         tests_failed++;
         $display("FAIL accept_reload: q=%h q_src=%0d q_valid=%b gnt=%b cnt=%0d, required 5 3 1 1000 2",
                  q, q_src, q_valid, gnt, load_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0001; din = 16'h000C; q_ready = 1'b0;
      tick();
      rst = 1'b1; q_ready = 1'b1;
      tick();
      tests_run++;
      if (q !== 4'h0 || q_valid !== 1'b0 || gnt !== 4'b0000 || load_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_mid: q=%h q_valid=%b gnt=%b cnt=%0d, required 0 0 0000 0",
                  q, q_valid, gnt, load_cnt);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || q !== 4'hC || q_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_regrant: gnt=%b q=%h q_valid=%b, required 0001 C 1", gnt, q, q_valid);
      end
   endtask

   task automatic test_counter_wrap();
      logic [3:0] v;
      do_reset();
      q_ready = 1'b1; req = 4'b0001;
      for (int i = 1; i <= 256; i++) begin
         v = 4'($urandom);
         din = {12'h000, v};
         tick();
         tests_run++;
         if (load_cnt !== 8'(i % 256) || q !== v || gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL cnt_wrap[%0d]: load_cnt=%0d q=%h gnt=%b, required %0d %h 0001",
                     i, load_cnt, q, gnt, i % 256, v);
         end
         tick();   // lane 0 is masked during its grant cycle
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 40) == 0);
         req     = 4'($urandom);
         din     = 16'($urandom);
         q_ready = ($urandom_range(0, 2) != 0);
         tick();
         tests_run++;
         if (gnt !== 4'(m_gnt) || q !== 4'(m_q) || q_src !== 2'(m_src) ||
             q_valid !== 1'(m_valid) || load_cnt !== 8'(m_cnt)) begin
            tests_failed++;
            $display("FAIL random[%0d]: gnt=%b q=%h src=%0d v=%b cnt=%0d, required %b %h %0d %0d %0d",
                     c, gnt, q, q_src, q_valid, load_cnt, 4'(m_gnt), 4'(m_q), m_src, m_valid, m_cnt);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; din = '0; q_ready = 1'b0;
      m_q = 0; m_src = 0; m_valid = 0; m_gnt = 0; m_cnt = 0; m_ptr = 0;
      test_reset();
      test_single_load();
      test_round_robin();
      test_back_to_back();
      test_reset_mid();
      test_counter_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
